// File: rtl/rosc_odometer_meas.sv
// Odometer measurement controller: enables a stressed/reference ring oscillator pair,
// counts synchronized rising edges of each over a programmed window and reports the counts.
module rosc_odometer_meas #(
    parameter int CNT_W       = 16,
    parameter int WIN_W       = 16,
    parameter int SETTLE_CYC  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIN_W-1:0]   win_len,
    output logic               busy,
    output logic               rosc_ref_en,
    output logic               rosc_str_en,
    input  logic               rosc_ref_in,
    input  logic               rosc_str_in,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [CNT_W-1:0]   ref_count,
    output logic [CNT_W-1:0]   str_count,
    output logic [CNT_W:0]     delta,
    output logic               overflow
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_COUNT  = 2'd2;
    localparam logic [1:0] S_REPORT = 2'd3;

    // One cycle counter serves both the settle phase and the count window.
    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam int CYC_W = (WIN_W > SET_W) ? WIN_W : SET_W;

    logic [1:0] osc_in;
    logic [1:0] rise;

    assign osc_in = {rosc_str_in, rosc_ref_in};

    // Index 0 is the reference oscillator, index 1 the stressed one.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q, sync_d;
            logic                   dly_q, dly_d;

            always_comb begin
                sync_d = {sync_q[SYNC_STAGES-2:0], osc_in[gi]};
                dly_d  = sync_q[SYNC_STAGES-1];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q <= '0;
                    dly_q  <= 1'b0;
                end else begin
                    sync_q <= sync_d;
                    dly_q  <= dly_d;
                end
            end

            assign rise[gi] = sync_q[SYNC_STAGES-1] & ~dly_q;
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [CYC_W-1:0] win_q, win_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] ref_q, ref_d;
    logic [CNT_W-1:0] str_q, str_d;
    logic [CNT_W:0]   delta_q, delta_d;
    logic             ovf_q, ovf_d;
    logic             en_q, en_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        cyc_d   = cyc_q;
        ref_d   = ref_q;
        str_d   = str_q;
        delta_d = delta_q;
        ovf_d   = ovf_q;
        en_d    = en_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    win_d   = CYC_W'(win_len);
                    cyc_d   = '0;
                    ref_d   = '0;
                    str_d   = '0;
                    delta_d = '0;
                    ovf_d   = 1'b0;
                    en_d    = 1'b1;
                    if (win_len == '0) begin
                        state_d = S_REPORT;
                        valid_d = 1'b1;
                    end else begin
                        state_d = S_SETTLE;
                        valid_d = 1'b0;
                    end
                end
            end
            S_SETTLE: begin
                if (cyc_q == CYC_W'(SETTLE_CYC - 1)) begin
                    cyc_d   = '0;
                    state_d = S_COUNT;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            S_COUNT: begin
                if (rise[0]) begin
                    if (ref_q == '1) ovf_d = 1'b1;
                    else             ref_d = ref_q + CNT_W'(1);
                end
                if (rise[1]) begin
                    if (str_q == '1) ovf_d = 1'b1;
                    else             str_d = str_q + CNT_W'(1);
                end
                // Delta uses the post-increment counts so it always matches the reported pair.
                if (cyc_q == win_q - CYC_W'(1)) begin
                    state_d = S_REPORT;
                    en_d    = 1'b0;
                    valid_d = 1'b1;
                    delta_d = {1'b0, ref_d} - {1'b0, str_d};
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            default: begin
                en_d = 1'b0;
                if (res_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            win_q   <= '0;
            cyc_q   <= '0;
            ref_q   <= '0;
            str_q   <= '0;
            delta_q <= '0;
            ovf_q   <= 1'b0;
            en_q    <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            cyc_q   <= cyc_d;
            ref_q   <= ref_d;
            str_q   <= str_d;
            delta_q <= delta_d;
            ovf_q   <= ovf_d;
            en_q    <= en_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign busy        = busy_q;
    assign rosc_ref_en = en_q;
    assign rosc_str_en = en_q;
    assign res_valid   = valid_q;
    assign ref_count   = ref_q;
    assign str_count   = str_q;
    assign delta       = delta_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_rosc_odometer_meas.sv
// Scoreboard bench for rosc_odometer_meas: a 16-bit instance for the main scenarios and
// a 4-bit counter instance for saturation, both fed by the same oscillator models.
module tb_rosc_odometer_meas;

    localparam int SETTLE = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic [15:0] win_len = '0;
    logic        res_ready = 1'b0;
    logic        busy, rosc_ref_en, rosc_str_en, res_valid, overflow;
    logic [15:0] ref_count, str_count;
    logic [16:0] delta;

    logic        s_start = 1'b0;
    logic [15:0] s_win = '0;
    logic        s_ready = 1'b0;
    logic        s_busy, s_ref_en, s_str_en, s_valid, s_ovf;
    logic [3:0]  s_ref, s_str;
    logic [4:0]  s_delta;

    logic rosc_ref_in = 1'b0;
    logic rosc_str_in = 1'b0;
    int   ref_half = 4;
    int   str_half = 5;
    logic str_level = 1'b0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int ref_exp;
        int ref_tol;
        int str_exp;
        int str_tol;
        bit ovf;
        int lat;
        int en_cyc;
    } exp_t;
    exp_t sb[$];

    rosc_odometer_meas #(.CNT_W(16), .WIN_W(16), .SETTLE_CYC(SETTLE), .SYNC_STAGES(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .win_len(win_len), .busy(busy),
        .rosc_ref_en(rosc_ref_en), .rosc_str_en(rosc_str_en),
        .rosc_ref_in(rosc_ref_in), .rosc_str_in(rosc_str_in),
        .res_valid(res_valid), .res_ready(res_ready),
        .ref_count(ref_count), .str_count(str_count), .delta(delta), .overflow(overflow)
    );

    rosc_odometer_meas #(.CNT_W(4), .WIN_W(16), .SETTLE_CYC(SETTLE), .SYNC_STAGES(2)) u_sat (
        .clk(clk), .rst(rst), .start(s_start), .win_len(s_win), .busy(s_busy),
        .rosc_ref_en(s_ref_en), .rosc_str_en(s_str_en),
        .rosc_ref_in(rosc_ref_in), .rosc_str_in(rosc_str_in),
        .res_valid(s_valid), .res_ready(s_ready),
        .ref_count(s_ref), .str_count(s_str), .delta(s_delta), .overflow(s_ovf)
    );

    // Divided oscillator models: toggle every *_half clk cycles, or hold a level when 0.
    initial begin
        int rph;
        int sph;
        rph = 0;
        sph = 0;
        forever begin
            @(negedge clk);
            if (ref_half > 0) begin
                rph++;
                if (rph >= ref_half) begin
                    rph = 0;
                    rosc_ref_in = ~rosc_ref_in;
                end
            end
            if (str_half > 0) begin
                sph++;
                if (sph >= str_half) begin
                    sph = 0;
                    rosc_str_in = ~rosc_str_in;
                end
            end else begin
                rosc_str_in = str_level;
            end
        end
    end

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic ack_result();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL ack_drop: res_valid=%0b busy=%0b, required 0/0", res_valid, busy);
        end
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic run_meas(input int win, input int rexp, input int rtol,
                            input int sexp, input int stol, input bit ovf, input bit ack);
        exp_t e;
        int   n;
        int   en_n;
        logic [16:0] d_exp;
        e.ref_exp = rexp; e.ref_tol = rtol;
        e.str_exp = sexp; e.str_tol = stol;
        e.ovf     = ovf;
        e.lat     = (win == 0) ? 1 : 1 + SETTLE + win;
        e.en_cyc  = (win == 0) ? 1 : SETTLE + win;
        sb.push_back(e);
        @(negedge clk);
        start   = 1'b1;
        win_len = win[15:0];
        @(posedge clk);
        #1;
        start   = 1'b0;
        win_len = 16'hFFFF;
        n    = 1;
        en_n = (rosc_ref_en && rosc_str_en) ? 1 : 0;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL start_accept: busy=%0b, required 1", busy);
        end
        while (res_valid !== 1'b1 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            if (rosc_ref_en && rosc_str_en) en_n++;
        end
        e = sb.pop_front();
        tests++;
        if (n !== e.lat) begin
            fails++;
            $display("FAIL latency: got %0d cycles, required %0d", n, e.lat);
        end
        tests++;
        if (en_n !== e.en_cyc) begin
            fails++;
            $display("FAIL enable_len: got %0d cycles, required %0d", en_n, e.en_cyc);
        end
        tests++;
        if (absdiff(int'(ref_count), e.ref_exp) > e.ref_tol) begin
            fails++;
            $display("FAIL ref_count: got %0d, required %0d+-%0d", ref_count, e.ref_exp, e.ref_tol);
        end
        tests++;
        if (absdiff(int'(str_count), e.str_exp) > e.str_tol) begin
            fails++;
            $display("FAIL str_count: got %0d, required %0d+-%0d", str_count, e.str_exp, e.str_tol);
        end
        d_exp = {1'b0, ref_count} - {1'b0, str_count};
        tests++;
        if (delta !== d_exp) begin
            fails++;
            $display("FAIL delta: got 0x%05h, required 0x%05h", delta, d_exp);
        end
        tests++;
        if (overflow !== e.ovf) begin
            fails++;
            $display("FAIL overflow: got %0b, required %0b", overflow, e.ovf);
        end
        $display("[TB] meas win=%0d ref=%0d str=%0d delta=0x%05h ovf=%0b lat=%0d", win,
                 ref_count, str_count, delta, overflow, n);
        if (ack) ack_result();
    endtask

    task automatic test_reset();
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b0 || rosc_ref_en !== 1'b0 || rosc_str_en !== 1'b0 || res_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: busy=%0b en=%0b/%0b valid=%0b, required all 0",
                     busy, rosc_ref_en, rosc_str_en, res_valid);
        end
        tests++;
        if (ref_count !== '0 || str_count !== '0 || delta !== '0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_data: ref=%0d str=%0d delta=%0d ovf=%0b, required all 0",
                     ref_count, str_count, delta, overflow);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_nominal();
        ref_half = 4;
        str_half = 5;
        run_meas(100, 12, 1, 10, 1, 1'b0, 1'b1);
    endtask

    task automatic test_zero_window();
        run_meas(0, 0, 0, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_negative_delta();
        ref_half = 6;
        str_half = 4;
        run_meas(96, 8, 1, 12, 1, 1'b0, 1'b0);
        tests++;
        if (delta[16] !== 1'b1) begin
            fails++;
            $display("FAIL delta_sign: got 0x%05h, required negative", delta);
        end
        ack_result();
    endtask

    task automatic test_backpressure();
        logic [15:0] r0, s0;
        logic [16:0] d0;
        logic        o0;
        ref_half = 4;
        str_half = 5;
        run_meas(100, 12, 1, 10, 1, 1'b0, 1'b0);
        r0 = ref_count; s0 = str_count; d0 = delta; o0 = overflow;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start   = (i % 3 == 0);
            win_len = 16'd7;
            @(posedge clk);
            #1;
            tests++;
            if (res_valid !== 1'b1 || busy !== 1'b1 || ref_count !== r0 || str_count !== s0 ||
                delta !== d0 || overflow !== o0) begin
                fails++;
                $display("FAIL hold_%0d: valid=%0b busy=%0b ref=%0d str=%0d delta=0x%05h ovf=%0b, required 1/1 %0d %0d 0x%05h %0b",
                         i, res_valid, busy, ref_count, str_count, delta, overflow, r0, s0, d0, o0);
            end
        end
        @(negedge clk);
        start = 1'b0;
        ack_result();
    endtask

    task automatic test_back_to_back();
        ref_half = 4;
        str_half = 5;
        run_meas(40, 5, 1, 4, 1, 1'b0, 1'b1);
        run_meas(40, 5, 1, 4, 1, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        bit seen;
        ref_half = 4;
        str_half = 5;
        @(negedge clk);
        start   = 1'b1;
        win_len = 16'd200;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (58) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (rosc_ref_en !== 1'b0 || rosc_str_en !== 1'b0 || busy !== 1'b0 ||
            ref_count !== '0 || str_count !== '0 || res_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: en=%0b/%0b busy=%0b ref=%0d str=%0d valid=%0b, required all 0",
                     rosc_ref_en, rosc_str_en, busy, ref_count, str_count, res_valid);
        end
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (250) begin
            @(posedge clk);
            #1;
            if (res_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL reset_discard: valid/busy seen=%0b, required 0", seen);
        end
        run_meas(100, 12, 1, 10, 1, 1'b0, 1'b1);
    endtask

    task automatic test_static_osc();
        ref_half  = 4;
        str_level = 1'b1;
        str_half  = 0;
        repeat (10) @(negedge clk);
        run_meas(64, 8, 1, 0, 0, 1'b0, 1'b1);
        str_level = 1'b0;
        str_half  = 5;
    endtask

    task automatic test_saturation();
        int n;
        ref_half = 4;
        str_half = 8;
        @(negedge clk);
        s_start = 1'b1;
        s_win   = 16'd200;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        n = 1;
        while (s_valid !== 1'b1 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests++;
        if (n !== 1 + SETTLE + 200) begin
            fails++;
            $display("FAIL sat_latency: got %0d, required %0d", n, 1 + SETTLE + 200);
        end
        tests++;
        if (s_ref !== 4'd15 || s_ovf !== 1'b1) begin
            fails++;
            $display("FAIL sat_ref: ref=%0d ovf=%0b, required 15/1", s_ref, s_ovf);
        end
        tests++;
        if (absdiff(int'(s_str), 12) > 1) begin
            fails++;
            $display("FAIL sat_str: got %0d, required 12+-1", s_str);
        end
        tests++;
        if (s_delta !== 5'd15 - {1'b0, s_str}) begin
            fails++;
            $display("FAIL sat_delta: got 0x%02h, required 0x%02h", s_delta, 5'd15 - {1'b0, s_str});
        end
        $display("[TB] sat ref=%0d str=%0d delta=0x%02h ovf=%0b lat=%0d", s_ref, s_str, s_delta, s_ovf, n);
        @(negedge clk);
        s_ready = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (s_valid !== 1'b0 || s_busy !== 1'b0) begin
            fails++;
            $display("FAIL sat_ack: valid=%0b busy=%0b, required 0/0", s_valid, s_busy);
        end
        @(negedge clk);
        s_ready = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nominal();
        test_zero_window();
        test_negative_delta();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_static_osc();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rosc_odometer_meas.md
Name: rosc_odometer_meas

Overview:
- Measurement controller for the odometer sensor pair: one stressed ring oscillator and one reference ring oscillator, both built from NOR delay chains with a select input.
- Drives each oscillator's select/enable input.
- Brings the oscillator outputs, divided externally to below clk/4, into the clk domain and counts their rising edges over a programmed window.
- Reports both counts and their signed difference through a valid/ready result interface to the readout logic.

Parameters:
- CNT_W, 16, width of each edge counter.
- WIN_W, 16, width of the window-length input (window length in clk cycles).
- SETTLE_CYC, 8, clk cycles the oscillators run after enable before counting starts (must be ≥1).
- SYNC_STAGES, 2, flops in each oscillator-input synchronizer (≥2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request a measurement; sampled only in IDLE.
- win_len  in  WIN_W  count window in clk cycles; captured when start is accepted.
- busy  out  1  high whenever state ≠ IDLE.
- rosc_ref_en  out  1  enable/select to the reference oscillator.
- rosc_str_en  out  1  enable/select to the stressed oscillator.
- rosc_ref_in  in  1  asynchronous divided reference oscillator output.
- rosc_str_in  in  1  asynchronous divided stressed oscillator output.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- ref_count  out  CNT_W  reference rising-edge count.
- str_count  out  CNT_W  stressed rising-edge count.
- delta  out  CNT_W+1  signed ref_count − str_count, two's complement.
- overflow  out  1  either counter saturated during the window.

Behaviour:
- Reset state: all registered outputs 0, state IDLE.
  - This includes busy, both enables, res_valid, counts, delta, overflow and the synchronizer flops.
  - A reset asserted in any state returns to IDLE on the next edge. Enables drop that same edge and any partial result is discarded.
- Input synchronizers:
  - Each oscillator input passes through SYNC_STAGES flops, then one edge-detect flop.
  - A rising edge is detected when the synchronized value is 1 and the delayed copy is 0.
  - The synchronizers run continuously in every state.
- FSM states: IDLE, SETTLE, COUNT, REPORT.
- IDLE:
  - start=1 at edge t → win_len captured, counters cleared, overflow cleared, res_valid=0.
  - From t+1: busy=1 and both enables=1.
  - Next state is SETTLE, or REPORT when the captured win_len==0 (zero counts, delta 0, overflow 0).
- SETTLE:
  - Lasts exactly SETTLE_CYC cycles; enables held high; edges are ignored.
  - Then goes to COUNT.
- COUNT:
  - Lasts exactly win_len cycles.
  - Each cycle in which a detected rising edge is present increments the corresponding counter by 1.
  - Counters saturate at 2^CNT_W−1. An increment attempted at saturation sets overflow (sticky until next start).
  - On the last COUNT cycle:
    - Enables drop on the next edge.
    - delta is registered as a zero-extended (ref − str) in CNT_W+1 bits.
    - Next state is REPORT.
- REPORT:
  - res_valid=1; ref_count, str_count, delta and overflow are stable and held while res_valid=1 and res_ready=0.
  - res_valid & res_ready at edge u → res_valid=0 and state IDLE at u+1; busy low at u+1.
  - start is ignored in REPORT.
  - A new start is accepted no earlier than edge u+1.
- start while busy=1 is ignored; win_len changes while busy have no effect.
- Timing: the first counted edge is one sampled in the first COUNT cycle. Edges still in the synchronizer pipeline when COUNT ends are dropped, an accepted ±SYNC_STAGES+1-cycle aperture.
- Total latency from start accepted to res_valid = 1 + SETTLE_CYC + win_len cycles (1 cycle when win_len=0).

Test Plan:
- Nominal measurement:
  - Stimulus: rst 4 cycles; start, win_len=100; ref toggles every 4 clk (period 8), str every 5 clk (period 10).
  - Response: ref_count 12±1, str_count 10±1, delta = ref−str exactly, overflow=0.
  - Timing: res_valid rises 109 cycles after start acceptance; enables high exactly SETTLE_CYC+100 cycles.
- Saturation:
  - Stimulus: CNT_W=4, win_len=200, ref period 8.
  - Response: ref_count=15, overflow=1, delta=15−str_count.
- Zero window and negative delta:
  - Stimulus: win_len=0.
  - Response: res_valid 1 cycle after start, all counts 0, enables never exceed 1 cycle.
  - Stimulus: str faster than ref.
  - Response: delta negative, e.g. 8−12 → 0x1FFFC for CNT_W=16.
- Handshake backpressure:
  - Stimulus: hold res_ready=0 for 20 cycles, toggle the oscillator inputs and pulse start.
  - Response: outputs unchanged, start ignored, busy=1.
  - Stimulus: res_ready=1.
  - Response: res_valid and busy drop next cycle; start one cycle later is accepted.
- Reset mid-operation:
  - Stimulus: assert rst during COUNT after ~50 cycles.
  - Response: next edge enables=0, busy=0, counts=0, res_valid never asserted.
  - Stimulus: subsequent start.
  - Response: full nominal result.
- Static oscillator:
  - Stimulus: hold rosc_str_in=1 throughout, win_len=64.
  - Response: str_count=0; no edge detected from a level present before COUNT.
